// File: rtl/inter_ip_axil_pkg.sv
// Shared definitions for the AXI4-Lite register bank that fronts the crypto cores.
//   - AXI response codes
//   - write-path and read-path FSM state types
//   - register count, and the position of the register index within a byte address
//   - byte-lane merge helper used when a write commits
package inter_ip_axil_pkg;

   localparam int unsigned NUM_REGS    = 4;
   localparam int unsigned REG_IDX_LSB = 2;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      W_IDLE,
      W_HAVE_ADDR,
      W_HAVE_DATA,
      W_RESP
   } wr_state_e;

   typedef enum logic {
      R_IDLE,
      R_RESP
   } rd_state_e;

   // Lanes with strb[b]=1 take the new byte; all other lanes keep the current byte.
   function automatic logic [31:0] apply_wstrb(input logic [31:0] cur,
                                              input logic [31:0] data,
                                              input logic [3:0]  strb);
      logic [31:0] res;
      res = cur;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) res[8*b +: 8] = data[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/inter_ip_axil_wr_ctrl.sv
// Write-channel controller for the AXI4-Lite register bank.
// Captures AW and W independently (either order, or the same cycle) into one-entry
// buffers, commits once both are present, then holds the B response until BREADY.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   awaddr/awvalid/awready        AW channel
//   wdata/wstrb/wvalid/wready     W channel
//   bresp/bvalid/bready           B channel
//   commit                        one-cycle strobe on the edge an in-range write commits
//   commit_idx/data/strb          target register, write data and byte enables for that commit
module inter_ip_axil_wr_ctrl
   import inter_ip_axil_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [ADDR_WIDTH-1:0]   awaddr,
   input  logic                    awvalid,
   output logic                    awready,
   input  logic [DATA_WIDTH-1:0]   wdata,
   input  logic [DATA_WIDTH/8-1:0] wstrb,
   input  logic                    wvalid,
   output logic                    wready,
   output logic [1:0]              bresp,
   output logic                    bvalid,
   input  logic                    bready,
   output logic                    commit,
   output logic [1:0]              commit_idx,
   output logic [DATA_WIDTH-1:0]   commit_data,
   output logic [DATA_WIDTH/8-1:0] commit_strb
);

   wr_state_e               state_q, state_d;
   logic [ADDR_WIDTH-1:0]   aw_buf_q, aw_buf_d;
   logic [DATA_WIDTH-1:0]   w_data_q, w_data_d;
   logic [DATA_WIDTH/8-1:0] w_strb_q, w_strb_d;
   logic                    awready_q, awready_d;
   logic                    wready_q, wready_d;
   logic [1:0]              bresp_q, bresp_d;

   logic                    aw_hs, w_hs, aw_full, w_full, fire, oor;
   logic [ADDR_WIDTH-1:0]   eff_addr;

   assign aw_hs   = awvalid & awready_q;
   assign w_hs    = wvalid & wready_q;
   assign aw_full = (state_q == W_HAVE_ADDR);
   assign w_full  = (state_q == W_HAVE_DATA);

   // Commit on the edge that completes the second handshake; the half that arrives on
   // that edge bypasses its buffer.
   assign fire     = (aw_full | aw_hs) & (w_full | w_hs);
   assign eff_addr = aw_full ? aw_buf_q : awaddr;
   assign oor      = (eff_addr >> 4) != '0;

   assign commit      = fire & ~oor;
   assign commit_idx  = eff_addr[REG_IDX_LSB +: 2];
   assign commit_data = w_full ? w_data_q : wdata;
   assign commit_strb = w_full ? w_strb_q : wstrb;

   always_comb begin
      state_d  = state_q;
      aw_buf_d = aw_buf_q;
      w_data_d = w_data_q;
      w_strb_d = w_strb_q;
      bresp_d  = bresp_q;

      if (aw_hs) aw_buf_d = awaddr;
      if (w_hs) begin
         w_data_d = wdata;
         w_strb_d = wstrb;
      end

      case (state_q)
         W_IDLE, W_HAVE_ADDR, W_HAVE_DATA: begin
            if (fire) begin
               state_d = W_RESP;
               bresp_d = oor ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            end else if (aw_hs) begin
               state_d = W_HAVE_ADDR;
            end else if (w_hs) begin
               state_d = W_HAVE_DATA;
            end
         end
         W_RESP: begin
            if (bready) state_d = W_IDLE;
         end
         default: state_d = W_IDLE;
      endcase

      // Readies are registered copies of the next-state decode, so they stay low in the
      // cycle right after reset and track the state exactly afterwards.
      awready_d = (state_d == W_IDLE) || (state_d == W_HAVE_DATA);
      wready_d  = (state_d == W_IDLE) || (state_d == W_HAVE_ADDR);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= W_IDLE;
         aw_buf_q  <= '0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bresp_q   <= AXI_RESP_OKAY;
      end else begin
         state_q   <= state_d;
         aw_buf_q  <= aw_buf_d;
         w_data_q  <= w_data_d;
         w_strb_q  <= w_strb_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bresp_q   <= bresp_d;
      end
   end

   assign awready = awready_q;
   assign wready  = wready_q;
   assign bresp   = bresp_q;
   assign bvalid  = (state_q == W_RESP);

endmodule

// File: rtl/inter_ip_axil_regs.sv
// AXI4-Lite slave register bank for the crypto cores: four 32-bit software registers.
// Ports:
//   ACLK, ARESET          clock, synchronous active-high reset
//   S_AXI_AW*/W*/B*       write address, write data and write response channels
//   S_AXI_AR*/R*          read address and read data channels
//   reg_q                 flattened register contents, register i at [32*i +: 32]
//   reg_wr_pulse          one-cycle strobe per register after a committed write
// Register index is ADDR[3:2]; any set address bit above bit 3 gives SLVERR.
module inter_ip_axil_regs
   import inter_ip_axil_pkg::*;
#(
   parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
   parameter int unsigned C_S_AXI_ADDR_WIDTH = 4,
   parameter int unsigned NUM_REGS           = inter_ip_axil_pkg::NUM_REGS
) (
   input  logic                               ACLK,
   input  logic                               ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]      S_AXI_AWADDR,
   input  logic [2:0]                         S_AXI_AWPROT,
   input  logic                               S_AXI_AWVALID,
   output logic                               S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]      S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]    S_AXI_WSTRB,
   input  logic                               S_AXI_WVALID,
   output logic                               S_AXI_WREADY,
   output logic [1:0]                         S_AXI_BRESP,
   output logic                               S_AXI_BVALID,
   input  logic                               S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]      S_AXI_ARADDR,
   input  logic [2:0]                         S_AXI_ARPROT,
   input  logic                               S_AXI_ARVALID,
   output logic                               S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]      S_AXI_RDATA,
   output logic [1:0]                         S_AXI_RRESP,
   output logic                               S_AXI_RVALID,
   input  logic                               S_AXI_RREADY,
   output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_q,
   output logic [NUM_REGS-1:0]                reg_wr_pulse
);

   logic                              commit;
   logic [1:0]                        commit_idx;
   logic [C_S_AXI_DATA_WIDTH-1:0]     commit_data;
   logic [C_S_AXI_DATA_WIDTH/8-1:0]   commit_strb;

   logic [C_S_AXI_DATA_WIDTH-1:0]     regs_q [NUM_REGS];
   logic [NUM_REGS-1:0]               pulse_q;

   rd_state_e                         r_state_q, r_state_d;
   logic                              arready_q, arready_d;
   logic [C_S_AXI_DATA_WIDTH-1:0]     rdata_q, rdata_d;
   logic [1:0]                        rresp_q, rresp_d;
   logic                              ar_hs, ar_oor;
   logic [1:0]                        ar_idx;

   // Protection attributes carry no meaning for this bank.
   logic unused_prot;
   assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

   inter_ip_axil_wr_ctrl #(
      .ADDR_WIDTH (C_S_AXI_ADDR_WIDTH),
      .DATA_WIDTH (C_S_AXI_DATA_WIDTH)
   ) u_wr_ctrl (
      .clk         (ACLK),
      .rst         (ARESET),
      .awaddr      (S_AXI_AWADDR),
      .awvalid     (S_AXI_AWVALID),
      .awready     (S_AXI_AWREADY),
      .wdata       (S_AXI_WDATA),
      .wstrb       (S_AXI_WSTRB),
      .wvalid      (S_AXI_WVALID),
      .wready      (S_AXI_WREADY),
      .bresp       (S_AXI_BRESP),
      .bvalid      (S_AXI_BVALID),
      .bready      (S_AXI_BREADY),
      .commit      (commit),
      .commit_idx  (commit_idx),
      .commit_data (commit_data),
      .commit_strb (commit_strb)
   );

   // Register array and write strobes.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
         pulse_q <= '0;
      end else begin
         pulse_q <= '0;
         if (commit) begin
            regs_q[commit_idx]  <= apply_wstrb(regs_q[commit_idx], commit_data, commit_strb);
            pulse_q[commit_idx] <= 1'b1;
         end
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
      assign reg_q[g*C_S_AXI_DATA_WIDTH +: C_S_AXI_DATA_WIDTH] = regs_q[g];
   end
   assign reg_wr_pulse = pulse_q;

   // Read path. RDATA samples regs_q before any same-edge commit lands, so a colliding
   // read returns the pre-write value.
   assign ar_hs  = S_AXI_ARVALID & arready_q;
   assign ar_oor = (S_AXI_ARADDR >> 4) != '0;
   assign ar_idx = S_AXI_ARADDR[REG_IDX_LSB +: 2];

   always_comb begin
      r_state_d = r_state_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      case (r_state_q)
         R_IDLE: begin
            if (ar_hs) begin
               r_state_d = R_RESP;
               rdata_d   = ar_oor ? '0 : regs_q[ar_idx];
               rresp_d   = ar_oor ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            end
         end
         R_RESP: begin
            if (S_AXI_RREADY) r_state_d = R_IDLE;
         end
      endcase
      arready_d = (r_state_d == R_IDLE);
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_state_q <= R_IDLE;
         arready_q <= 1'b0;
         rdata_q   <= '0;
         rresp_q   <= AXI_RESP_OKAY;
      end else begin
         r_state_q <= r_state_d;
         arready_q <= arready_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
      end
   end

   assign S_AXI_ARREADY = arready_q;
   assign S_AXI_RVALID  = (r_state_q == R_RESP);
   assign S_AXI_RDATA   = rdata_q;
   assign S_AXI_RRESP   = rresp_q;

endmodule

// File: tb/tb_inter_ip_axil_regs.sv
// Directed bench for inter_ip_axil_regs, built with a 5-bit address so that 0x10 and
// above are out of range. Expected B and R responses are queued when a transaction is
// issued and compared when the DUT presents the response.
module tb_inter_ip_axil_regs;

   localparam int unsigned AW = 5;
   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   logic          ACLK = 1'b0;
   logic          ARESET;
   logic [AW-1:0] S_AXI_AWADDR;
   logic [2:0]    S_AXI_AWPROT;
   logic          S_AXI_AWVALID;
   logic          S_AXI_AWREADY;
   logic [31:0]   S_AXI_WDATA;
   logic [3:0]    S_AXI_WSTRB;
   logic          S_AXI_WVALID;
   logic          S_AXI_WREADY;
   logic [1:0]    S_AXI_BRESP;
   logic          S_AXI_BVALID;
   logic          S_AXI_BREADY;
   logic [AW-1:0] S_AXI_ARADDR;
   logic [2:0]    S_AXI_ARPROT;
   logic          S_AXI_ARVALID;
   logic          S_AXI_ARREADY;
   logic [31:0]   S_AXI_RDATA;
   logic [1:0]    S_AXI_RRESP;
   logic          S_AXI_RVALID;
   logic          S_AXI_RREADY;
   logic [127:0]  reg_q;
   logic [3:0]    reg_wr_pulse;

   always #5 ACLK = ~ACLK;

   inter_ip_axil_regs #(
      .C_S_AXI_DATA_WIDTH (32),
      .C_S_AXI_ADDR_WIDTH (AW),
      .NUM_REGS           (4)
   ) dut (
      .ACLK          (ACLK),
      .ARESET        (ARESET),
      .S_AXI_AWADDR  (S_AXI_AWADDR),
      .S_AXI_AWPROT  (S_AXI_AWPROT),
      .S_AXI_AWVALID (S_AXI_AWVALID),
      .S_AXI_AWREADY (S_AXI_AWREADY),
      .S_AXI_WDATA   (S_AXI_WDATA),
      .S_AXI_WSTRB   (S_AXI_WSTRB),
      .S_AXI_WVALID  (S_AXI_WVALID),
      .S_AXI_WREADY  (S_AXI_WREADY),
      .S_AXI_BRESP   (S_AXI_BRESP),
      .S_AXI_BVALID  (S_AXI_BVALID),
      .S_AXI_BREADY  (S_AXI_BREADY),
      .S_AXI_ARADDR  (S_AXI_ARADDR),
      .S_AXI_ARPROT  (S_AXI_ARPROT),
      .S_AXI_ARVALID (S_AXI_ARVALID),
      .S_AXI_ARREADY (S_AXI_ARREADY),
      .S_AXI_RDATA   (S_AXI_RDATA),
      .S_AXI_RRESP   (S_AXI_RRESP),
      .S_AXI_RVALID  (S_AXI_RVALID),
      .S_AXI_RREADY  (S_AXI_RREADY),
      .reg_q         (reg_q),
      .reg_wr_pulse  (reg_wr_pulse)
   );

   int unsigned tests = 0;
   int unsigned fails = 0;
   logic [1:0]  bq[$];
   logic [33:0] rq[$];  // {rdata, rresp}
   logic [31:0] model [4];

   function automatic logic [31:0] reg_at(input int i);
      return reg_q[i*32 +: 32];
   endfunction

   function automatic logic [127:0] model_flat();
      return {model[3], model[2], model[1], model[0]};
   endfunction

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic wait_b(input logic [3:0] exp_pulse);
      logic [1:0] e;
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         if (S_AXI_BVALID) begin
            seen = 1'b1;
            e = bq.pop_front();
            check("bresp", S_AXI_BRESP, e);
            check("wr_pulse", reg_wr_pulse, exp_pulse);
            tick();
            check("wr_pulse_one_cycle", reg_wr_pulse, 4'b0000);
         end else begin
            tick();
         end
      end
      check("bvalid_seen", seen, 1'b1);
   endtask

   task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] exp_resp,
                            input logic [3:0] exp_pulse);
      bit aw_done, w_done;
      logic hs_aw, hs_w;
      aw_done = 1'b0;
      w_done  = 1'b0;
      bq.push_back(exp_resp);
      if (exp_resp == OKAY) begin
         for (int b = 0; b < 4; b++) begin
            if (strb[b]) model[addr[3:2]][8*b +: 8] = data[8*b +: 8];
         end
      end
      S_AXI_AWADDR  = addr;
      S_AXI_AWVALID = 1'b1;
      S_AXI_WDATA   = data;
      S_AXI_WSTRB   = strb;
      S_AXI_WVALID  = 1'b1;
      for (int i = 0; i < 20 && !(aw_done && w_done); i++) begin
         hs_aw = S_AXI_AWVALID && S_AXI_AWREADY;
         hs_w  = S_AXI_WVALID && S_AXI_WREADY;
         tick();
         if (hs_aw) begin
            S_AXI_AWVALID = 1'b0;
            aw_done = 1'b1;
         end
         if (hs_w) begin
            S_AXI_WVALID = 1'b0;
            w_done = 1'b1;
         end
      end
      S_AXI_AWVALID = 1'b0;
      S_AXI_WVALID  = 1'b0;
      check("wr_handshakes", {aw_done, w_done}, 2'b11);
      wait_b(exp_pulse);
   endtask

   task automatic axi_read(input logic [AW-1:0] addr, input logic [31:0] exp_data,
                           input logic [1:0] exp_resp);
      logic [33:0] e;
      bit done, seen;
      logic hs;
      done = 1'b0;
      seen = 1'b0;
      rq.push_back({exp_data, exp_resp});
      S_AXI_ARADDR  = addr;
      S_AXI_ARVALID = 1'b1;
      for (int i = 0; i < 20 && !done; i++) begin
         hs = S_AXI_ARVALID && S_AXI_ARREADY;
         tick();
         if (hs) begin
            S_AXI_ARVALID = 1'b0;
            done = 1'b1;
         end
      end
      S_AXI_ARVALID = 1'b0;
      check("ar_handshake", done, 1'b1);
      for (int i = 0; i < 20 && !seen; i++) begin
         if (S_AXI_RVALID) begin
            seen = 1'b1;
            e = rq.pop_front();
            check("rdata", S_AXI_RDATA, e[33:2]);
            check("rresp", S_AXI_RRESP, e[1:0]);
         end
         tick();
      end
      check("rvalid_seen", seen, 1'b1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      ARESET        = 1'b1;
      S_AXI_AWADDR  = '0;
      S_AXI_AWPROT  = 3'b000;
      S_AXI_AWVALID = 1'b0;
      S_AXI_WDATA   = '0;
      S_AXI_WSTRB   = 4'h0;
      S_AXI_WVALID  = 1'b0;
      S_AXI_BREADY  = 1'b1;
      S_AXI_ARADDR  = '0;
      S_AXI_ARPROT  = 3'b000;
      S_AXI_ARVALID = 1'b0;
      S_AXI_RREADY  = 1'b1;
      for (int i = 0; i < 4; i++) model[i] = '0;

      // Reset state.
      tick();
      check("rst_awready", S_AXI_AWREADY, 1'b0);
      check("rst_wready", S_AXI_WREADY, 1'b0);
      check("rst_arready", S_AXI_ARREADY, 1'b0);
      check("rst_bvalid", S_AXI_BVALID, 1'b0);
      check("rst_rvalid", S_AXI_RVALID, 1'b0);
      check("rst_bresp", S_AXI_BRESP, 2'b00);
      check("rst_rresp", S_AXI_RRESP, 2'b00);
      check("rst_rdata", S_AXI_RDATA, 32'h0);
      check("rst_reg_q", reg_q, 128'h0);
      check("rst_pulse", reg_wr_pulse, 4'h0);
      ARESET = 1'b0;
      tick();
      check("post_rst_awready", S_AXI_AWREADY, 1'b1);
      check("post_rst_wready", S_AXI_WREADY, 1'b1);
      check("post_rst_arready", S_AXI_ARREADY, 1'b1);

      // Basic write then read-back of all four registers.
      for (int i = 0; i < 4; i++) begin
         logic [AW-1:0] a;
         logic [3:0]    p;
         a = AW'(i * 4);
         p = 4'b0001 << i;
         axi_write(a, 32'(i + 1), 4'hF, OKAY, p);
      end
      for (int i = 0; i < 4; i++) begin
         logic [AW-1:0] a;
         a = AW'(i * 4);
         axi_read(a, 32'(i + 1), OKAY);
      end
      check("regs_after_basic", reg_q, 128'h00000004_00000003_00000002_00000001);

      // W arrives three cycles before AW.
      bq.push_back(OKAY);
      S_AXI_WDATA  = 32'hDEADBEEF;
      S_AXI_WSTRB  = 4'hF;
      S_AXI_WVALID = 1'b1;
      tick();
      S_AXI_WVALID = 1'b0;
      check("wready_low_after_w", S_AXI_WREADY, 1'b0);
      check("awready_have_data", S_AXI_AWREADY, 1'b1);
      tick();
      tick();
      check("no_bvalid_before_aw", S_AXI_BVALID, 1'b0);
      S_AXI_AWADDR  = 5'h04;
      S_AXI_AWVALID = 1'b1;
      tick();
      S_AXI_AWVALID = 1'b0;
      model[1] = 32'hDEADBEEF;
      check("bvalid_after_aw", S_AXI_BVALID, 1'b1);
      check("reg1_deadbeef", reg_at(1), 32'hDEADBEEF);
      wait_b(4'b0010);

      // Byte strobes, including a write with no lanes enabled.
      axi_write(5'h00, 32'hFFFFFFFF, 4'hF, OKAY, 4'b0001);
      axi_write(5'h00, 32'h12345678, 4'b0101, OKAY, 4'b0001);
      check("reg0_strobed", reg_at(0), 32'hFF34FF78);
      axi_read(5'h00, 32'hFF34FF78, OKAY);
      axi_write(5'h0C, 32'hCAFEF00D, 4'h0, OKAY, 4'b1000);
      check("reg3_zero_strb", reg_at(3), 32'h00000004);

      // Out-of-range accesses, and ignored low address bits.
      axi_write(5'h10, 32'h000000AA, 4'hF, SLVERR, 4'b0000);
      check("regs_after_oor", reg_q, model_flat());
      axi_read(5'h10, 32'h0, SLVERR);
      axi_read(5'h07, 32'hDEADBEEF, OKAY);

      // Back-pressure on B and R, with a read of reg2 colliding with a write to reg2.
      S_AXI_BREADY = 1'b0;
      S_AXI_RREADY = 1'b0;
      bq.push_back(OKAY);
      rq.push_back({32'h00000003, OKAY});
      S_AXI_AWADDR  = 5'h08;
      S_AXI_AWVALID = 1'b1;
      S_AXI_WDATA   = 32'h00000005;
      S_AXI_WSTRB   = 4'hF;
      S_AXI_WVALID  = 1'b1;
      S_AXI_ARADDR  = 5'h08;
      S_AXI_ARVALID = 1'b1;
      tick();
      S_AXI_AWVALID = 1'b0;
      S_AXI_WVALID  = 1'b0;
      S_AXI_ARVALID = 1'b0;
      model[2] = 32'h00000005;
      check("collide_pulse", reg_wr_pulse, 4'b0100);
      check("collide_reg2", reg_at(2), 32'h00000005);
      for (int i = 0; i < 5; i++) begin
         check("stall_bvalid", S_AXI_BVALID, 1'b1);
         check("stall_bresp", S_AXI_BRESP, bq[0]);
         check("stall_rvalid", S_AXI_RVALID, 1'b1);
         check("stall_rdata", S_AXI_RDATA, rq[0][33:2]);
         check("stall_rresp", S_AXI_RRESP, rq[0][1:0]);
         check("stall_awready", S_AXI_AWREADY, 1'b0);
         check("stall_wready", S_AXI_WREADY, 1'b0);
         check("stall_arready", S_AXI_ARREADY, 1'b0);
         tick();
      end
      void'(bq.pop_front());
      void'(rq.pop_front());
      S_AXI_BREADY = 1'b1;
      S_AXI_RREADY = 1'b1;
      tick();
      check("release_bvalid", S_AXI_BVALID, 1'b0);
      check("release_rvalid", S_AXI_RVALID, 1'b0);
      check("release_awready", S_AXI_AWREADY, 1'b1);
      check("release_arready", S_AXI_ARREADY, 1'b1);
      axi_read(5'h08, 32'h00000005, OKAY);

      // Reset while the AW buffer is full.
      S_AXI_AWADDR  = 5'h08;
      S_AXI_AWVALID = 1'b1;
      tick();
      S_AXI_AWVALID = 1'b0;
      check("have_addr_awready", S_AXI_AWREADY, 1'b0);
      check("have_addr_wready", S_AXI_WREADY, 1'b1);
      check("have_addr_reg2", reg_at(2), 32'h00000005);
      ARESET = 1'b1;
      tick();
      ARESET = 1'b0;
      for (int i = 0; i < 4; i++) model[i] = '0;
      check("abort_reg2", reg_at(2), 32'h0);
      check("abort_bvalid", S_AXI_BVALID, 1'b0);
      check("abort_awready_low", S_AXI_AWREADY, 1'b0);
      tick();
      check("abort_awready_high", S_AXI_AWREADY, 1'b1);
      for (int i = 0; i < 3; i++) begin
         check("abort_no_bvalid", S_AXI_BVALID, 1'b0);
         tick();
      end
      check("abort_regs_zero", reg_q, model_flat());
      axi_write(5'h08, 32'h00000077, 4'hF, OKAY, 4'b0100);
      axi_read(5'h08, 32'h00000077, OKAY);

      check("scoreboard_empty", 32'(bq.size() + rq.size()), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
